// File: rtl/chunked_cla_subtractor_if.sv
// Operand/result handshake bundle for the chunked CLA subtractor.
// The master drives operands and consumes results; the slave is the subtractor.
interface chunked_cla_subtractor_if #(
    parameter int NUMBITS = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic               borrowin;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               borrowout;
    logic               overflow;

    modport master (
        output in_valid, A, B, borrowin, out_ready,
        input  in_ready, out_valid, result, borrowout, overflow
    );

    modport slave (
        input  in_valid, A, B, borrowin, out_ready,
        output in_ready, out_valid, result, borrowout, overflow
    );
endinterface

// File: rtl/chunked_cla_subtractor.sv
// Multi-cycle subtractor: result = A - B - borrowin, one CHUNK-bit CLA slice per
// clock with the inter-slice carry (inverted borrow) held in a register.

module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         acc;
    logic         pp;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened lookahead sum of products, not a ripple chain.
    always_comb begin
        c    = '0;
        c[0] = cin;
        acc  = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < W; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int k = i; k >= 0; k--) begin
                acc = acc | (pp & g[k]);
                pp  = pp & p[k];
            end
            c[i+1] = acc | (pp & cin);
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

module chunked_cla_subtractor #(
    parameter int NUMBITS = 16,
    parameter int CHUNK   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    chunked_cla_subtractor_if.slave  bus
);
    localparam int N    = NUMBITS / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int MSB  = NUMBITS - 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    if ((CHUNK < 1) || (NUMBITS % CHUNK != 0)) begin : g_bad_param
        $error("chunked_cla_subtractor: NUMBITS (%0d) must be a multiple of CHUNK (%0d)",
               NUMBITS, CHUNK);
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q,     state_d;
    logic [NUMBITS-1:0] a_q,         a_d;
    logic [NUMBITS-1:0] nb_q,        nb_d;
    logic               carry_q,     carry_d;
    logic [IDXW-1:0]    idx_q,       idx_d;
    logic [NUMBITS-1:0] result_q,    result_d;
    logic               borrowout_q, borrowout_d;
    logic               overflow_q,  overflow_d;

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_nb;
    logic [CHUNK-1:0]   slice_s;
    logic               slice_c;

    assign slice_a  = a_q[idx_q*CHUNK +: CHUNK];
    assign slice_nb = nb_q[idx_q*CHUNK +: CHUNK];

    cla_slice #(.W(CHUNK)) u_slice (
        .a    (slice_a),
        .b    (slice_nb),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        nb_d        = nb_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        result_d    = result_q;
        borrowout_d = borrowout_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    nb_d    = ~bus.B;
                    carry_d = ~bus.borrowin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*CHUNK +: CHUNK] = slice_s;
                carry_d = slice_c;
                if (idx_q == LAST_IDX) begin
                    idx_d       = '0;
                    borrowout_d = ~slice_c;
                    // nb_q holds ~B, so equal MSBs here mean A and B had different signs.
                    overflow_d  = (a_q[MSB] == nb_q[MSB]) && (slice_s[CHUNK-1] != a_q[MSB]);
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            borrowout_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            borrowout_q <= borrowout_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.borrowout = borrowout_q;
    assign bus.overflow  = overflow_q;
endmodule
